// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a selectable read mode:
//   FWFT = 0 : registered read, r_data updates the cycle after an accepted r_inc.
//   FWFT = 1 : first-word-fall-through, an output register presents the head
//              word whenever r_empty is low; r_inc pops it.
//
// Handshake: a write is accepted on a rising edge when w_inc is high and w_full
// (registered) is low; a read is accepted when r_inc is high and r_empty
// (registered) is low. Requests against a full/empty FIFO are dropped and set
// the matching sticky error flag. No output depends combinationally on w_inc
// or r_inc.
module sync_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_SIZE        = 4,
  parameter int ALMOST_FULL_BUF  = 1,
  parameter int ALMOST_EMPTY_BUF = 1,
  parameter bit FWFT             = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_inc,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_full,
  output logic                  w_almost_full,
  output logic                  w_overflow,
  input  logic                  r_inc,
  output logic                  r_empty,
  output logic                  r_almost_empty,
  output logic                  r_underflow,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [ADDR_SIZE:0]    count
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] AF_C    = (ADDR_SIZE+1)'(DEPTH - ALMOST_FULL_BUF);
  localparam logic [ADDR_SIZE:0] AE_C    = (ADDR_SIZE+1)'(ALMOST_EMPTY_BUF);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_SIZE:0]    wptr;
  logic [ADDR_SIZE:0]    rptr;
  logic [ADDR_SIZE:0]    mem_cnt;   // words still in the array (excludes the FWFT head)
  logic                  out_valid; // FWFT head register holds a word
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_rd;    // array word moves to r_data this edge

  // Status flags decoded purely from registered state.
  assign w_full         = (count == DEPTH_C);
  assign w_almost_full  = (count >= AF_C);
  assign r_almost_empty = (count <= AE_C);
  assign r_empty        = FWFT ? !out_valid : (count == '0);

  // Accept decisions and array-read strobe for the selected read mode.
  always_comb begin
    wr_acc  = w_inc && !w_full;
    rd_acc  = r_inc && !r_empty;
    mem_cnt = count;
    mem_rd  = rd_acc;
    if (FWFT) begin
      // The head register counts toward occupancy, so the array holds one less.
      mem_cnt = count - {{ADDR_SIZE{1'b0}}, out_valid};
      // Refill the head when it is empty or being popped, if a word is stored.
      mem_rd  = (mem_cnt != '0) && (!out_valid || rd_acc);
    end
  end

  // Storage array; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wptr[ADDR_SIZE-1:0]] <= w_data;
    end
  end

  // Pointers, occupancy count and the read data / head register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      r_data    <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (mem_rd) begin
        rptr   <= rptr + 1'b1;
        r_data <= mem[rptr[ADDR_SIZE-1:0]];
      end
      if (mem_rd) begin
        out_valid <= 1'b1;
      end else if (rd_acc) begin
        out_valid <= 1'b0;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_inc && w_full) begin
        w_overflow <= 1'b1;
      end
      if (r_inc && r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule
